// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared constants and types for the instruction prefetch front end.
// Imported by the fetch unit top.
package fetch_prefetch_unit_pkg;

  localparam logic [31:0] FETCH_RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned FETCH_ALIGN_MASK = 3;
  localparam int unsigned FETCH_STEP = 4;

  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_FILL,
    RSP_DROP
  } rsp_route_e;

endpackage

// File: rtl/fetch_slot_ring.sv
// Slot ring for in-flight and returned fetches: pc/data storage,
// filled bits, alloc/fill/head pointers and occupancy counters.
module fetch_slot_ring #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic [XLEN-1:0] push_pc_i,
  input  logic            fill_i,
  input  logic [31:0]     fill_data_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic [CW-1:0]   unfilled_o,
  output logic            head_valid_o,
  output logic [XLEN-1:0] head_pc_o,
  output logic [31:0]     head_data_o
);

  logic [XLEN-1:0]  pc_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [AW-1:0]    alloc_q;
  logic [AW-1:0]    fill_q;
  logic [AW-1:0]    head_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    unfill_q;
  logic             do_fill;

  // A response with nothing outstanding is a protocol error; drop it.
  assign do_fill = fill_i & (unfill_q != '0);

  assign full_o       = count_q == CW'(DEPTH);
  assign unfilled_o   = unfill_q;
  assign head_valid_o = filled_q[head_q] & (count_q != '0);
  assign head_pc_o    = pc_q[head_q];
  assign head_data_o  = data_q[head_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alloc_q  <= '0;
      fill_q   <= '0;
      head_q   <= '0;
      count_q  <= '0;
      unfill_q <= '0;
      filled_q <= '0;
    end else if (flush_i) begin
      alloc_q  <= '0;
      fill_q   <= '0;
      head_q   <= '0;
      count_q  <= '0;
      unfill_q <= '0;
      filled_q <= '0;
    end else begin
      if (push_i) begin
        alloc_q <= alloc_q + 1'b1;
        filled_q[alloc_q] <= 1'b0;
      end
      if (do_fill) begin
        fill_q <= fill_q + 1'b1;
        filled_q[fill_q] <= 1'b1;
      end
      if (pop_i) begin
        head_q <= head_q + 1'b1;
      end
      count_q  <= count_q + CW'(push_i) - CW'(pop_i);
      unfill_q <= unfill_q + CW'(push_i) - CW'(do_fill);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push_i & ~flush_i) begin
        pc_q[alloc_q] <= push_pc_i;
      end
      if (do_fill & ~flush_i) begin
        data_q[fill_q] <= fill_data_i;
      end
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: sequential PC generation, multi-outstanding
// fetch into a slot ring, and redirect with in-flight response dropping.
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN = 32,
  parameter int unsigned     DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  // Stale responses can pile up across back-to-back redirects.
  localparam int unsigned DW = $clog2(DEPTH) + 4;

  logic            run_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [DW-1:0]   drop_q;
  logic [DW-1:0]   drop_d;
  logic            full;
  logic            issue;
  logic            pop;
  logic            head_valid;
  logic [CW-1:0]   unfilled;
  rsp_route_e      route;

  assign imem_req_valid = run_q & ~full & ~redirect_valid;
  assign issue          = imem_req_valid & imem_req_ready;
  assign pop            = head_valid & inst_ready & ~redirect_valid;
  assign inst_valid     = head_valid;
  assign imem_addr      = pc_q;

  always_comb begin
    route = RSP_NONE;
    if (imem_rsp_valid) begin
      route = (redirect_valid || drop_q != '0) ? RSP_DROP : RSP_FILL;
    end
  end

  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    unique case (1'b1)
      redirect_valid: begin
        pc_d   = redirect_pc & ~XLEN'(FETCH_ALIGN_MASK);
        drop_d = drop_q + DW'(unfilled) - DW'(imem_rsp_valid);
      end
      default: begin
        if (issue) begin
          pc_d = pc_q + XLEN'(FETCH_STEP);
        end
        if (route == RSP_DROP) begin
          drop_d = drop_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q  <= 1'b0;
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      run_q  <= 1'b1;
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  fetch_slot_ring #(
    .XLEN (XLEN),
    .DEPTH(DEPTH)
  ) u_ring (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_valid),
    .push_i      (issue),
    .push_pc_i   (pc_q),
    .fill_i      (route == RSP_FILL),
    .fill_data_i (imem_rsp_data),
    .pop_i       (pop),
    .full_o      (full),
    .unfilled_o  (unfilled),
    .head_valid_o(head_valid),
    .head_pc_o   (inst_pc),
    .head_data_o (inst_data)
  );

  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> (drop_q != '0 || unfilled != '0));

endmodule
